// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path.
// Frame geometry, arbiter states and baud counter sizing.
package uart_pkg;

  localparam int FRAME_BITS   = 10;
  localparam int STOP_IDX     = FRAME_BITS - 1;
  localparam int DEF_CLK_BAUD = 10;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    HOLD
  } arb_state_t;

  function automatic int clk_baud_w(input int cpb);
    return (cpb > 1) ? $clog2(cpb) : 1;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART serializer: start bit, 8 data bits LSB first, stop bit.
// done_o marks the last stop-bit cycle so a new frame can follow.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BAUD = DEF_CLK_BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_i,
  input  logic       start_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       tx
);

  localparam int BW = clk_baud_w(CLOCKS_PER_BAUD);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLOCKS_PER_BAUD - 1);

  logic [BW-1:0]         baud_cnt;
  logic [3:0]            bit_idx;
  logic [FRAME_BITS-1:0] shreg;
  logic                  busy_q;
  logic                  baud_end;

  assign baud_end = (baud_cnt == BAUD_LAST);
  assign done_o   = busy_q & baud_end & (bit_idx == 4'(STOP_IDX));
  assign busy_o   = busy_q;
  assign tx       = shreg[0];

  // Shift the frame out one bit per baud period; line idles high.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '1;
      busy_q   <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else if (start_i) begin
      shreg    <= {1'b1, data_i, 1'b0};
      busy_q   <= 1'b1;
      baud_cnt <= '0;
      bit_idx  <= '0;
    end else if (busy_q) begin
      if (baud_end) begin
        baud_cnt <= '0;
        shreg    <= {1'b1, shreg[FRAME_BITS-1:1]};
        if (bit_idx == 4'(STOP_IDX)) begin
          busy_q  <= 1'b0;
          bit_idx <= '0;
        end else begin
          bit_idx <= bit_idx + 4'd1;
        end
      end else begin
        baud_cnt <= baud_cnt + BW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-locked arbiter in front of one UART serializer.
// Owner keeps the line until a last byte or an idle lock timeout.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int N_REQ           = 4,
  parameter int CLOCKS_PER_BAUD = 10,
  parameter int LOCK_TIMEOUT    = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   valid_i,
  input  logic [N_REQ-1:0]   last_i,
  input  logic [8*N_REQ-1:0] data_i,
  output logic [N_REQ-1:0]   ready_o,
  output logic [N_REQ-1:0]   grant_o,
  output logic               busy_o,
  output logic               tx
);

  localparam int PW = $clog2(N_REQ);
  localparam int TW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TO_LAST =
    TW'((LOCK_TIMEOUT > 0) ? LOCK_TIMEOUT - 1 : 0);

  arb_state_t       state_q, state_n;
  logic [PW-1:0]    ptr_q, ptr_n;
  logic [PW-1:0]    owner_q, owner_n;
  logic [N_REQ-1:0] grant_q, grant_n;
  logic             last_q, last_n;
  logic [TW-1:0]    idle_q, idle_n;

  logic [PW-1:0] scan, win, acc_idx;
  logic          found, rr_en, own_en, acc;
  logic [7:0]    ser_data;
  logic          ser_busy, ser_done;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (int'(p) == N_REQ - 1) ? '0 : p + PW'(1);
  endfunction

  function automatic logic [PW:0] rr_pick(
    input logic [PW-1:0]    p,
    input logic [N_REQ-1:0] v
  );
    logic          f;
    logic [PW-1:0] w;
    int            j;
    f = 1'b0;
    w = p;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(p) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!f && v[j]) begin
        f = 1'b1;
        w = PW'(j);
      end
    end
    return {f, w};
  endfunction

  // State, pointer, lock owner, timer and captured last flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      grant_q <= '0;
      last_q  <= 1'b0;
      idle_q  <= '0;
    end else begin
      state_q <= state_n;
      ptr_q   <= ptr_n;
      owner_q <= owner_n;
      grant_q <= grant_n;
      last_q  <= last_n;
      idle_q  <= idle_n;
    end
  end

  // Next-state, ready offer and accept handling.
  always_comb begin
    state_n = state_q;
    ptr_n   = ptr_q;
    owner_n = owner_q;
    grant_n = grant_q;
    last_n  = last_q;
    idle_n  = idle_q;
    ready_o = '0;
    scan    = ptr_q;
    rr_en   = 1'b0;
    own_en  = 1'b0;
    acc_idx = owner_q;
    unique case (state_q)
      IDLE: rr_en = 1'b1;
      SEND: begin
        if (ser_done) begin
          if (last_q) begin
            scan    = nxt(owner_q);
            ptr_n   = scan;
            grant_n = '0;
            state_n = IDLE;
            rr_en   = 1'b1;
          end else begin
            own_en = 1'b1;
            if (LOCK_TIMEOUT == 1) begin
              ptr_n   = nxt(owner_q);
              grant_n = '0;
              state_n = IDLE;
            end else begin
              state_n = HOLD;
              idle_n  = TW'(1);
            end
          end
        end
      end
      HOLD: begin
        own_en = 1'b1;
        if (!valid_i[owner_q]) begin
          if (LOCK_TIMEOUT != 0 && idle_q >= TO_LAST) begin
            ptr_n   = nxt(owner_q);
            grant_n = '0;
            state_n = IDLE;
          end else if (idle_q != '1) begin
            idle_n = idle_q + TW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
    {found, win} = rr_pick(scan, valid_i);
    if (rr_en && found) begin
      ready_o[win] = 1'b1;
      acc_idx      = win;
    end
    if (own_en) begin
      ready_o[owner_q] = 1'b1;
      acc_idx          = owner_q;
    end
    acc = valid_i[acc_idx] & ready_o[acc_idx];
    if (acc) begin
      owner_n          = acc_idx;
      grant_n          = '0;
      grant_n[acc_idx] = 1'b1;
      last_n           = last_i[acc_idx];
      idle_n           = '0;
      state_n          = SEND;
    end
  end

  // Byte mux from the accepted requester into the serializer.
  always_comb begin
    ser_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (PW'(i) == acc_idx) ser_data = data_i[8*i +: 8];
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = ser_busy;

  uart_tx #(
    .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD)
  ) u_tx (
    .clk    (clk),
    .rst    (rst),
    .data_i (ser_data),
    .start_i(acc),
    .busy_o (ser_busy),
    .done_o (ser_done),
    .tx     (tx)
  );

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
Shares one UART transmit serializer between N_REQ byte-stream requesters. It uses round-robin arbitration with message-level locking. Once a requester wins, it keeps the line until it sends a byte flagged last, or until its lock times out. Typical users are bridge responses, logic-analyzer readback and status messages, all on the single host tx line that the existing uart_rx receive path pairs with.

Parameters:
N_REQ, 4, number of requesters (2..8)
CLOCKS_PER_BAUD, 10, clk cycles per UART bit; must match the host-side uart_rx
LOCK_TIMEOUT, 1000, cycles the granted requester may idle mid-message before its lock is revoked; 0 disables the timeout

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
valid_i  in  N_REQ  requester i presents a byte
last_i  in  N_REQ  byte on requester i ends its message
data_i  in  8*N_REQ  byte for requester i in bits [8i+7:8i]
ready_o  out  N_REQ  byte accepted when valid_i[i] & ready_o[i]
grant_o  out  N_REQ  one-hot current owner; all-zero when unowned
busy_o  out  1  serializer transmitting a frame
tx  out  1  UART line, idle high

Behaviour:
- Reset (clk, rst synchronous active-high): tx=1, ready_o=0, grant_o=0, busy_o=0, state=IDLE, RR pointer=0.
- Reset mid-frame: tx returns high on the next edge and the frame is abandoned. No partial byte is resumed.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). Each bit is held CLOCKS_PER_BAUD cycles, so a frame is 10*CLOCKS_PER_BAUD cycles.
- States:
  - IDLE: ready_o[w] is combinationally high for w, the first requester with valid_i set, scanning from the pointer upward modulo N_REQ.
    - Accept: data captured, grant_o=onehot(w), go to SEND.
    - No valid: remain.
  - SEND: busy_o=1 and all ready_o=0. The start bit drives tx from the cycle after acceptance (k+1) through k+CPB. The stop bit occupies k+9CPB+1 .. k+10CPB.
    - In cycle k+10CPB the serializer reports done.
    - If the accepted byte had last_i=1: pointer=w+1 mod N_REQ, grant_o cleared, go to IDLE. ready_o for the next winner is evaluated in that same cycle k+10CPB.
    - Else: go to HOLD with ready_o[w]=1 in cycle k+10CPB.
  - HOLD: only ready_o[w] may be high; all other valids are ignored.
    - Accept by w: go to SEND.
    - Timeout: with LOCK_TIMEOUT>0, if valid_i[w]=0 for LOCK_TIMEOUT consecutive cycles, set pointer=w+1, clear grant, go to IDLE. The idle counter resets on every accept.
- Back-to-back: consecutive accepted bytes start exactly 10*CPB cycles apart, so there is no idle gap between frames.
- Inputs:
  - data_i/last_i are sampled only in the accept cycle.
  - Dropping valid_i without an accept is legal and has no effect.
- Simultaneous requests in IDLE: the lowest index at or above the pointer wins, with wrap-around.
- Grant: grant_o stays stable from the accept cycle to release.
- Internal counters: baud counter is clog2(CPB) bits and the bit index counts 0..9. The timeout counter saturates and never wraps.

Decomposition:
- Package uart_pkg holds:
  - FRAME_BITS=10 constant;
  - arb_state_t enum {IDLE, SEND, HOLD};
  - CLK_BAUD helper localparams.
- Sub-module uart_tx is the serializer:
  - ports clk, rst, data_i[7:0], start_i, busy_o, done_o, tx;
  - done_o pulses in the final stop-bit cycle.
- The arbiter contains only the FSM, the RR pointer, the lock timer and the capture register.

Test Plan:
1. Single byte: requester 2 sends 0xA5 with last=1, CPB=10. ready_o[2] is high in the valid cycle. tx is low for cycles 1-10, then data bits 1,0,1,0,0,1,0,1, then high. A loopback uart_rx outputs 0xA5 once, and busy_o falls at cycle 100.
2. Round-robin: all 4 valid with last=1, data 0x10..0x13. Frames go out in order 0,1,2,3, starting exactly 100 cycles apart with no gap. A second round also starts at requester 0 after the pointer wraps.
3. Lock: requester 1 sends a 3-byte message 0x41,0x42,0x43 (last on the third) while requester 0 holds valid high throughout. The tx order is 41,42,43, then requester 0's byte. grant_o stays 0010 for 300 cycles.
4. Timeout: LOCK_TIMEOUT=50. Requester 1 sends one byte with last=0, then drops valid, while requester 3 is valid. Requester 3 is accepted exactly 50 cycles after the first frame ends.
5. Reset: rst is asserted for one cycle during data bit 4 of 0xFF. tx goes high on the next edge and all outputs return to reset values. A following 0x00 frame is received correctly with no spurious byte.
6. Exhaustive: bytes 0x00..0xFF are looped back into uart_rx (CPB=10), both with 100-cycle gaps and back-to-back. Every byte is received exactly once and in order.
